// File: rtl/cpa_pkg.sv
// Shared types and sizing helpers for the iterative carry-propagate adder.
// The CPA_BYPASS_EN build option itself lives in cpa_iter.sv.
package cpa_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Keep at least one index bit so a single-chunk build still elaborates.
    function automatic int calc_idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/cpa_iter_if.sv
// Operand and result handshake bundle for cpa_iter.
// master = upstream/consumer side, slave = the adder.
interface cpa_iter_if
    import cpa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid, once raised, is held with stable data until that edge, and
    // ready never depends on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
        output in_valid, in_s, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_s, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/cpa_chunk_adder.sv
// CHUNK-bit ripple slice with carry in/out; one instance is time-shared
// over all chunks of the operand.
module cpa_chunk_adder
    import cpa_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    logic [CHUNK:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum   = w_total[CHUNK-1:0];
    assign o_cout  = w_total[CHUNK];

endmodule

// File: rtl/cpa_iter.sv
// Resolves the final CSA sum/carry pair into S + (C<<1), CHUNK bits per cycle.
// Define CPA_BYPASS_EN to finish in one cycle when the shifted carry is zero.
module cpa_iter
    import cpa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    cpa_iter_if.slave    bus,
    output state_t       o_state
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_res_nxt;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_b_zero;
    int               w_base;

    // The MSB of the carry vector shifts out of range and is dropped.
    assign w_b_in = {bus.in_c[WIDTH-2:0], 1'b0};

`ifdef CPA_BYPASS_EN
    assign w_b_zero = (w_b_in == '0);
`else
    assign w_b_zero = 1'b0;
`endif

    assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_base     = int'(r_idx) * CHUNK;

    always_comb begin
        w_a_chunk = r_a[w_base +: CHUNK];
        w_b_chunk = r_b[w_base +: CHUNK];
        w_res_nxt = r_res;
        w_res_nxt[w_base +: CHUNK] = w_chunk_sum;
    end

    cpa_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_b_zero ? ST_DONE : ST_ADD;
            end
            ST_ADD: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Result handshake and the next accept may share one edge.
                if (bus.out_ready) begin
                    if (w_accept) w_state_nxt = w_b_zero ? ST_DONE : ST_ADD;
                    else          w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.in_s;
            r_b     <= w_b_in;
            r_carry <= 1'b0;
            r_idx   <= '0;
            if (w_b_zero) begin
                r_sum  <= bus.in_s;
                r_cout <= 1'b0;
            end
        end else if (r_state == ST_ADD) begin
            r_res   <= w_res_nxt;
            r_carry <= w_chunk_cout;
            r_idx   <= r_idx + 1'b1;
            // Published outputs only move when DONE is entered.
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_chunk_cout;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign o_state       = r_state;

endmodule

// File: tb/tb_cpa_iter.sv
// Bench for cpa_iter: directed vectors, back-pressure, back-to-back, random
// traffic and a mid-operation reset, checked against a queued reference sum.
module tb_cpa_iter;
    import cpa_pkg::*;

    localparam int W = 64;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     cyc;
    int     n_vec;
    int     n_err;
    logic   seen;

    logic [W:0] exp_q[$];
    int         acc_q[$];
    int         lat_q[$];

    cpa_iter_if #(.WIDTH(W)) bus ();

    cpa_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W-1:0] b;
        b = {c[W-2:0], 1'b0};
        return {1'b0, s} + {1'b0, b};
    endfunction

    function automatic int exp_latency(input logic [W-1:0] c);
`ifdef CPA_BYPASS_EN
        if (c[W-2:0] == '0) return 1;
`endif
        return 4;
    endfunction

    // Scoreboard: push on an accept, pop on a result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
            seen = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    if (!seen) check_eq("unexpected_valid", 64'd1, 64'd0);
                    seen = !bus.out_ready;
                end else begin
                    if (!seen) begin
                        check_eq("latency", 64'(cyc - acc_q[0]), 64'(lat_q[0]));
                        seen = 1'b1;
                    end
                    if (bus.out_ready) begin
                        check_eq("sum", bus.out_sum, exp_q[0][W-1:0]);
                        check_eq("cout", 64'(bus.out_cout), 64'(exp_q[0][W]));
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                        seen = 1'b0;
                    end else begin
                        check_eq("hold_sum", bus.out_sum, exp_q[0][W-1:0]);
                        check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
                    end
                end
            end else begin
                seen = 1'b0;
                if (exp_q.size() != 0) check_eq("busy_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_s, bus.in_c));
                acc_q.push_back(cyc + 1);
                lat_q.push_back(exp_latency(bus.in_c));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid still high.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
        logic got;
        bus.in_s     = s;
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check_eq("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic collect(input logic rnd);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            got = bus.out_valid && bus.out_ready;
            @(posedge clk);
            #1;
        end
        if (!got) check_eq("collect_timeout", 64'd0, 64'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_valid();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.out_valid;
        end
        if (!got) check_eq("valid_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] s;
        logic [W-1:0] c;
        n_vec = 0;
        n_err = 0;
        seen  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_sum", bus.out_sum, 64'd0);
        check_eq("rst_out_cout", 64'(bus.out_cout), 64'd0);
        check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors.
        send(64'h0000_0000_0000_FFFF, 64'h1);
        bus.in_valid = 1'b0;
        collect(1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        bus.in_valid = 1'b0;
        collect(1'b0);
        send(64'h5, 64'h8000_0000_0000_0000);
        bus.in_valid = 1'b0;
        collect(1'b0);

        // Back-pressure with the next pair already waiting upstream.
        bus.out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
        bus.in_s = 64'hDEAD_BEEF_0000_0001;
        bus.in_c = 64'h7FFF_0000_FFFF_0000;
        wait_valid();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(64'hDEAD_BEEF_0000_0001, 64'h7FFF_0000_FFFF_0000);
        bus.in_valid = 1'b0;
        collect(1'b0);

        // Back-to-back with out_ready held high.
        bus.out_ready = 1'b1;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
        send(64'h0000_FFFF_0000_FFFF, 64'h0000_8000_0000_8000);
        bus.in_valid = 1'b0;
        collect(1'b0);

        // Random traffic including zero-carry operands.
        for (int n = 0; n < 24; n++) begin
            s = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       c = '0;
                1:       c = 64'h8000_0000_0000_0000;
                default: c = {$urandom, $urandom};
            endcase
            send(s, c);
            bus.in_valid = 1'b0;
            collect(1'b1);
        end

        // Reset two cycles into ADD aborts the operation.
        bus.out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h3);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("abort_out_sum", bus.out_sum, 64'd0);
        check_eq("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0008);
        bus.in_valid = 1'b0;
        collect(1'b0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
